// File: rtl/mem_cycle_ctl.sv
// mem_cycle_ctl: single-request memory-cycle sequencer for the PDP-8 datapath.
// One read or write runs at a time: ADDR, then WAIT_STATES wait cycles, then
// XFER (RAM strobe), then DONE. It drives the RAM address, data and write
// enable, and the hold/latch strobes of the downstream MD MultiLatch.
module mem_cycle_ctl #(
  parameter int unsigned WAIT_STATES = 1  // cycles spent in WAIT, 0..7
) (
  input  logic        SYSCLK,
  input  logic        RESET,
  input  logic        start,
  input  logic        write,
  input  logic [11:0] addr,
  input  logic [11:0] wdata,
  input  logic [11:0] mem_rdata,
  output logic [11:0] mem_addr,
  output logic [11:0] mem_wdata,
  output logic        mem_we,
  output logic        md_hold,
  output logic        md_latch,
  output logic [11:0] rdata,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_WAIT = 3'd2,
    S_XFER = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic [2:0] WaitInit = 3'(WAIT_STATES);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [11:0] addr_q, addr_d;
  logic [11:0] wdata_q, wdata_d;
  logic [11:0] rdata_q, rdata_d;

  // State register and request/result registers, cleared asynchronously.
  always_ff @(posedge SYSCLK or posedge RESET) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values; blocking ones would make the result order-dependent.
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic: sequence one request through ADDR/WAIT/XFER/DONE.
  always_comb begin
    // NOTE: every variable gets a hold value first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = addr;
          wdata_d = wdata;
          wr_d    = write;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        cnt_d   = WaitInit;
        state_d = (WaitInit == 3'd0) ? S_XFER : S_WAIT;
      end
      S_WAIT: begin
        // The count loaded in ADDR is consumed one per cycle; leaving on 1
        // makes WAIT last exactly WAIT_STATES cycles.
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = S_XFER;
      end
      S_XFER: begin
        if (!wr_q) rdata_d = mem_rdata;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;  // unused encodings recover to IDLE
    endcase
  end

  // Strobes decoded from registered state only, so they cannot glitch on
  // input changes and drop immediately when reset clears the state.
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign mem_we    = (state_q == S_XFER) && wr_q;
  assign md_hold   = !((state_q == S_XFER) && !wr_q);
  assign md_latch  = (state_q == S_DONE) && !wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule
